// File: rtl/serv_ibus_fetch.sv
// ----------------------------------------------------------------------------
// serv_ibus_fetch
//
// Single-entry instruction fetch unit between the PC unit and a Wishbone
// classic instruction bus. A one-cycle fetch request starts a bus cycle at
// the requested address. The returned word is held in a one-deep buffer
// until decode accepts it. A flush (jump/trap redirect) discards any pending
// or buffered instruction.
//
// Optional feature (macro SERV_IBUS_TIMEOUT_EN):
//   When defined, a bus cycle without ack is aborted after TIMEOUT_CYCLES
//   cycles, and o_fetch_err pulses for one cycle. When undefined, the bus
//   waits indefinitely and o_fetch_err is tied 0.
//
// Ports
//   clk           sole clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_pc          fetch address from the PC unit
//   i_fetch_req   one-cycle request to fetch the instruction at i_pc
//   i_flush       discard pending/buffered instruction
//   o_ibus_adr    registered bus address
//   o_ibus_cyc    bus cycle active
//   i_ibus_rdt    bus read data, valid with i_ibus_ack
//   i_ibus_ack    bus acknowledge, single cycle
//   o_insn        buffered instruction word to decode
//   o_insn_valid  o_insn holds a valid instruction
//   i_insn_ready  decode accepts o_insn this cycle
//   o_misalign    one-cycle pulse, requested pc has bit 0 set
//   o_fetch_err   one-cycle pulse, bus fetch timed out
// ----------------------------------------------------------------------------
module serv_ibus_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    input  logic        i_fetch_req,
    input  logic        i_flush,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_ack,
    output logic [31:0] o_insn,
    output logic        o_insn_valid,
    input  logic        i_insn_ready,
    output logic        o_misalign,
    output logic        o_fetch_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [31:0] adr_q,      adr_d;
    logic        cyc_q,      cyc_d;
    logic [31:0] insn_q,     insn_d;
    logic        valid_q,    valid_d;
    logic        misalign_q, misalign_d;
    logic        fetch_err_q, fetch_err_d;
    logic        discard_q,  discard_d;

    // A flush always wins over a same-cycle fetch request.
    logic req_ok;
    assign req_ok = i_fetch_req & ~i_flush;

`ifdef SERV_IBUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        adr_d       = adr_q;
        cyc_d       = cyc_q;
        insn_d      = insn_q;
        valid_d     = valid_q;
        discard_d   = discard_q;
        misalign_d  = 1'b0;
        fetch_err_d = 1'b0;
`ifdef SERV_IBUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    if (i_pc[0]) begin
                        misalign_d = 1'b1;
                    end else begin
                        adr_d   = i_pc;
                        cyc_d   = 1'b1;
                        state_d = ST_BUS;
`ifdef SERV_IBUS_TIMEOUT_EN
                        cnt_d   = 16'd0;
`endif
                    end
                end
            end

            ST_BUS: begin
                if (i_ibus_ack) begin
                    // Ack wins over a same-cycle timeout; a pending or
                    // same-cycle flush drops the returned word.
                    cyc_d     = 1'b0;
                    discard_d = 1'b0;
                    if (discard_q || i_flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        insn_d  = i_ibus_rdt;
                        valid_d = 1'b1;
                        state_d = ST_FULL;
                    end
                end else begin
                    // The bus cycle cannot be withdrawn on flush; remember to
                    // drop whatever comes back.
                    if (i_flush) begin
                        discard_d = 1'b1;
                    end
`ifdef SERV_IBUS_TIMEOUT_EN
                    if (cnt_q == TIMEOUT_LAST) begin
                        cyc_d       = 1'b0;
                        fetch_err_d = 1'b1;
                        discard_d   = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end

            ST_FULL: begin
                if (i_flush) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (i_insn_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    // Back-to-back fetch: start the next bus cycle directly.
                    if (i_fetch_req) begin
                        if (i_pc[0]) begin
                            misalign_d = 1'b1;
                        end else begin
                            adr_d   = i_pc;
                            cyc_d   = 1'b1;
                            state_d = ST_BUS;
`ifdef SERV_IBUS_TIMEOUT_EN
                            cnt_d   = 16'd0;
`endif
                        end
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cyc_d     = 1'b0;
                valid_d   = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            adr_q       <= 32'd0;
            cyc_q       <= 1'b0;
            insn_q      <= 32'd0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            cyc_q       <= cyc_d;
            insn_q      <= insn_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
            fetch_err_q <= fetch_err_d;
            discard_q   <= discard_d;
        end
    end

`ifdef SERV_IBUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign o_ibus_adr   = adr_q;
    assign o_ibus_cyc   = cyc_q;
    assign o_insn       = insn_q;
    assign o_insn_valid = valid_q;
    assign o_misalign   = misalign_q;
    assign o_fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_serv_ibus_fetch.sv
// ----------------------------------------------------------------------------
// tb_serv_ibus_fetch
//
// Directed bench for serv_ibus_fetch. Inputs change on the falling edge,
// outputs are sampled on the following falling edge (half a cycle after the
// active rising edge). Timeout scenarios apply only when
// SERV_IBUS_TIMEOUT_EN is defined; otherwise the indefinite-wait behaviour
// is checked instead.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serv_ibus_fetch;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic        i_fetch_req;
    logic        i_flush;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic [31:0] i_ibus_rdt;
    logic        i_ibus_ack;
    logic [31:0] o_insn;
    logic        o_insn_valid;
    logic        i_insn_ready;
    logic        o_misalign;
    logic        o_fetch_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serv_ibus_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_pc        (i_pc),
        .i_fetch_req (i_fetch_req),
        .i_flush     (i_flush),
        .o_ibus_adr  (o_ibus_adr),
        .o_ibus_cyc  (o_ibus_cyc),
        .i_ibus_rdt  (i_ibus_rdt),
        .i_ibus_ack  (i_ibus_ack),
        .o_insn      (o_insn),
        .o_insn_valid(o_insn_valid),
        .i_insn_ready(i_insn_ready),
        .o_misalign  (o_misalign),
        .o_fetch_err (o_fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a one-cycle fetch request and advance to the next sample point.
    task automatic fetch(input logic [31:0] pc);
        i_pc        = pc;
        i_fetch_req = 1'b1;
        step();
        i_fetch_req = 1'b0;
    endtask

    // Drive a one-cycle ack with data and advance to the next sample point.
    task automatic ack(input logic [31:0] rdt);
        i_ibus_rdt = rdt;
        i_ibus_ack = 1'b1;
        step();
        i_ibus_ack = 1'b0;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_pc         = 32'd0;
        i_fetch_req  = 1'b0;
        i_flush      = 1'b0;
        i_ibus_rdt   = 32'd0;
        i_ibus_ack   = 1'b0;
        i_insn_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_cyc",   32'(o_ibus_cyc),   32'd0);
        check("rst_valid", 32'(o_insn_valid), 32'd0);
        check("rst_adr",   o_ibus_adr,        32'd0);
        check("rst_insn",  o_insn,            32'd0);
        check("rst_mis",   32'(o_misalign),   32'd0);
        check("rst_err",   32'(o_fetch_err),  32'd0);
        i_rst_n = 1'b1;
        step();

        // Basic fetch: cyc high for 3 cycles, ack in the third
        fetch(32'h0000_0100);
        check("f1_cyc1", 32'(o_ibus_cyc), 32'd1);
        check("f1_adr",  o_ibus_adr,      32'h0000_0100);
        step();
        check("f1_cyc2", 32'(o_ibus_cyc), 32'd1);
        step();
        check("f1_cyc3", 32'(o_ibus_cyc), 32'd1);
        check("f1_adr3", o_ibus_adr,      32'h0000_0100);
        check("f1_nv3",  32'(o_insn_valid), 32'd0);
        ack(32'h0000_0013);
        check("f1_cyc_drop", 32'(o_ibus_cyc),   32'd0);
        check("f1_valid",    32'(o_insn_valid), 32'd1);
        check("f1_insn",     o_insn,            32'h0000_0013);

        // FULL held 4 cycles; a fetch request without ready is ignored
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                i_pc        = 32'h0000_0300;
                i_fetch_req = 1'b1;
            end
            step();
            i_fetch_req = 1'b0;
            check("full_hold_valid", 32'(o_insn_valid), 32'd1);
            check("full_hold_insn",  o_insn,            32'h0000_0013);
            check("full_hold_cyc",   32'(o_ibus_cyc),   32'd0);
        end

        // Ready plus back-to-back fetch
        i_insn_ready = 1'b1;
        fetch(32'h0000_0104);
        i_insn_ready = 1'b0;
        check("b2b_valid", 32'(o_insn_valid), 32'd0);
        check("b2b_cyc",   32'(o_ibus_cyc),   32'd1);
        check("b2b_adr",   o_ibus_adr,        32'h0000_0104);
        ack(32'h0050_0093);
        check("b2b_capt_valid", 32'(o_insn_valid), 32'd1);
        check("b2b_capt_insn",  o_insn,            32'h0050_0093);

        // Ready without fetch -> IDLE, insn retained
        i_insn_ready = 1'b1;
        step();
        i_insn_ready = 1'b0;
        check("rdy_valid",  32'(o_insn_valid), 32'd0);
        check("rdy_cyc",    32'(o_ibus_cyc),   32'd0);
        check("rdy_retain", o_insn,            32'h0050_0093);

        // Ack outside BUS is ignored
        ack(32'hCAFE_0001);
        check("stray_ack_valid", 32'(o_insn_valid), 32'd0);
        check("stray_ack_insn",  o_insn,            32'h0050_0093);

        // Flush one cycle after bus start, ack two cycles later
        fetch(32'h0000_0108);
        check("fl_cyc0", 32'(o_ibus_cyc), 32'd1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("fl_cyc1", 32'(o_ibus_cyc), 32'd1);
        step();
        check("fl_cyc2", 32'(o_ibus_cyc), 32'd1);
        ack(32'hDEAD_BEEF);
        check("fl_cyc_drop", 32'(o_ibus_cyc),   32'd0);
        check("fl_valid",    32'(o_insn_valid), 32'd0);
        check("fl_insn",     o_insn,            32'h0050_0093);
        step();
        check("fl_valid_late", 32'(o_insn_valid), 32'd0);

        // Back in IDLE: a new fetch starts; flush and ack in the same cycle
        fetch(32'h0000_010C);
        check("fa_cyc", 32'(o_ibus_cyc), 32'd1);
        check("fa_adr", o_ibus_adr,      32'h0000_010C);
        i_flush = 1'b1;
        ack(32'h1234_5678);
        i_flush = 1'b0;
        check("fa_cyc_drop", 32'(o_ibus_cyc),   32'd0);
        check("fa_valid",    32'(o_insn_valid), 32'd0);

        // Misaligned pc: one-cycle pulse, no bus cycle
        fetch(32'h0000_0201);
        check("mis_pulse", 32'(o_misalign), 32'd1);
        check("mis_cyc",   32'(o_ibus_cyc), 32'd0);
        step();
        check("mis_clear", 32'(o_misalign), 32'd0);
        check("mis_cyc2",  32'(o_ibus_cyc), 32'd0);

        // pc[1] set is legal and passed through unmodified
        fetch(32'h0000_0202);
        check("c_cyc", 32'(o_ibus_cyc), 32'd1);
        check("c_adr", o_ibus_adr,      32'h0000_0202);
        check("c_mis", 32'(o_misalign), 32'd0);
        ack(32'h1111_1111);
        check("c_valid", 32'(o_insn_valid), 32'd1);
        check("c_insn",  o_insn,            32'h1111_1111);

        // FULL + flush cancels a same-cycle fetch
        i_flush = 1'b1;
        fetch(32'h0000_0400);
        i_flush = 1'b0;
        check("ff_valid", 32'(o_insn_valid), 32'd0);
        check("ff_cyc",   32'(o_ibus_cyc),   32'd0);
        step();
        check("ff_cyc2",  32'(o_ibus_cyc),   32'd0);

        // Asynchronous reset mid-BUS, late ack after release ignored
        fetch(32'h0000_0500);
        check("ar_cyc_pre", 32'(o_ibus_cyc), 32'd1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("ar_cyc_async",   32'(o_ibus_cyc),   32'd0);
        check("ar_valid_async", 32'(o_insn_valid), 32'd0);
        check("ar_adr_async",   o_ibus_adr,        32'd0);
        step();
        i_rst_n = 1'b1;
        ack(32'hBAD0_BAD0);
        check("ar_late_valid", 32'(o_insn_valid), 32'd0);
        check("ar_late_cyc",   32'(o_ibus_cyc),   32'd0);
        check("ar_late_insn",  o_insn,            32'd0);

`ifdef SERV_IBUS_TIMEOUT_EN
        // No ack: cyc high 4 cycles then abort with one error pulse
        fetch(32'h0000_0600);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            check("to_cyc_hi", 32'(o_ibus_cyc),  32'd1);
            check("to_err_lo", 32'(o_fetch_err), 32'd0);
        end
        step();
        check("to_cyc_drop", 32'(o_ibus_cyc),   32'd0);
        check("to_err",      32'(o_fetch_err),  32'd1);
        check("to_valid",    32'(o_insn_valid), 32'd0);
        step();
        check("to_err_clr",  32'(o_fetch_err),  32'd0);
        // A fresh fetch proves the unit went back to IDLE
        fetch(32'h0000_0700);
        check("to_idle_cyc", 32'(o_ibus_cyc), 32'd1);
        check("to_idle_adr", o_ibus_adr,      32'h0000_0700);
        step();
        step();
        step();
        // Ack in the terminal cycle wins
        ack(32'h0000_0073);
        check("tw_valid", 32'(o_insn_valid), 32'd1);
        check("tw_insn",  o_insn,            32'h0000_0073);
        check("tw_err",   32'(o_fetch_err),  32'd0);
        check("tw_cyc",   32'(o_ibus_cyc),   32'd0);
`else
        // Without the timeout the bus waits indefinitely
        fetch(32'h0000_0600);
        for (int i = 0; i < 300; i++) begin
            step();
            if (o_fetch_err !== 1'b0 || o_ibus_cyc !== 1'b1) break;
        end
        check("nt_cyc_hold", 32'(o_ibus_cyc),  32'd1);
        check("nt_err_lo",   32'(o_fetch_err), 32'd0);
        check("nt_adr",      o_ibus_adr,       32'h0000_0600);
        ack(32'h0000_0073);
        check("nt_valid", 32'(o_insn_valid), 32'd1);
        check("nt_insn",  o_insn,            32'h0000_0073);
        check("nt_err2",  32'(o_fetch_err),  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
